btn_led_ctrl: RTL and testbench
===============================

// Module: btn_led_ctrl
// PURPOSE
//   N-channel button-to-LED controller: each button (active-low, asynchronous to the clock) is
//   synchronised, debounced and edge-detected, then drives its own active-low LED.
//   Per channel, the LED either toggles on each press or follows the button (momentary).
//   Sits between board button pins and LED pins. Debounced press/release pulses are
//   exported so other logic can consume them.
// PARAMETERS
//   N_CH          4      number of button/LED channels (>=1)
//   DEBOUNCE_CYC  50000  consecutive stable cycles needed to accept a new level (>=2; use 4 in sim)
//   CNT_W         $clog2(DEBOUNCE_CYC+1)  debounce counter width (derived, localparam)
// PORTS
//   i_clk            in   1     system clock
//   i_rst_n          in   1     asynchronous reset, active-low
//   i_btn_n          in   N_CH  raw buttons, 0 = pressed, asynchronous to i_clk
//   i_mode           in   N_CH  per-channel mode: 0 = toggle, 1 = momentary (follow button)
//   i_clr            in   1     synchronous clear of all LED states (all LEDs off)
//   o_led_n          out  N_CH  LEDs, 0 = lit
//   o_btn_state      out  N_CH  debounced button level, 1 = pressed
//   o_press_pulse    out  N_CH  1-cycle pulse on debounced press
//   o_release_pulse  out  N_CH  1-cycle pulse on debounced release
// BEHAVIOUR
//   Reset (i_rst_n=0, takes effect immediately, without a clock edge):
//   - sync FFs = 1; debounced level = released; counters = 0; pulses = 0; LED state = off.
//   - Result: o_led_n = all 1, o_btn_state = 0, o_press_pulse = 0, o_release_pulse = 0.
//   Synchroniser: 2-FF chain per channel. Only the second stage (sync2) feeds the debouncer.
//   Debounce, per channel, with independent counters:
//   - sync2 == stable level: counter <= 0.
//   - sync2 != stable level and counter < DEBOUNCE_CYC-1: counter <= counter+1.
//   - sync2 != stable level and counter == DEBOUNCE_CYC-1: stable <= sync2, counter <= 0.
//   - Any return to the stable level before acceptance restarts the count from 0.
//   - Glitches shorter than DEBOUNCE_CYC cycles at sync2 are ignored.
//   Edge detect (registered):
//   - o_press_pulse[k] = 1 for exactly one cycle, the cycle after stable goes released->pressed.
//   - o_release_pulse[k] behaves the same way for pressed->released.
//   - o_btn_state follows the debounced level.
//   Latency: let E0 be the first edge that samples the new level on i_btn_n.
//   - Debounced level changes at edge E(D+1), where D = DEBOUNCE_CYC.
//   - The pulse and the LED update happen at edge E(D+2).
//   LED state update, per channel, registered:
//   - i_clr=1: state <= off. i_clr has priority over press, toggle and momentary.
//   - Else if i_mode[k]=1: state <= debounced pressed level, delayed 1 cycle to align with pulses.
//   - Else if o_press_pulse condition: state <= ~state. Release does not change the state.
//   Mode change:
//   - toggle->momentary: the LED follows the button from the next cycle.
//   - momentary->toggle: the LED holds its current value.
//   Output: o_led_n = ~LED state (active-low).
//   Simultaneous events: channels are fully independent. Any mix of presses and releases in one
//   cycle produces all corresponding pulses in the same cycle.
//   i_clr does not suppress pulses.
//   Reset mid-debounce discards the partial count. After reset is released, a new change needs
//   a full D cycles.
// TESTING (DEBOUNCE_CYC=4, N_CH=4)
//   1. i_rst_n=0 with i_btn_n=4'h0 -> o_led_n=4'hF, all pulses 0, o_btn_state=0.
//      After release, all 4 presses are accepted by E6.
//   2. Toggle ch0: i_btn_n[0]=0 from E0 -> o_press_pulse[0]=1 only at E6, o_led_n[0]=0 from E6.
//      Release -> o_release_pulse[0] 6 edges later, LED stays lit.
//      Second press -> o_led_n[0]=1.
//   3. Glitch: i_btn_n[1]=0 for 3 cycles, then 1 -> no pulse, o_btn_state[1]=0, o_led_n[1]=1.
//      Bounce pattern 0,1,0,0,0,0 -> press accepted, counted from the last 0-run.
//   4. Momentary ch2: i_mode[2]=1, hold press 10 cycles -> o_led_n[2]=0 from E6 until 6 edges
//      after release, then 1.
//   5. All 4 pressed at the same edge -> o_press_pulse=4'hF in one cycle.
//      i_clr=1 in that same cycle -> o_led_n=4'hF next cycle, pulses still seen.
//   6. Reset mid-debounce: press ch3, assert i_rst_n=0 at count 2 -> outputs return to reset
//      values immediately.
//      Keep button held after reset release -> press pulse exactly 6 edges after the first
//      post-reset sampling edge.

Source files
------------

// File: rtl/btn_led_ctrl.sv
// N-channel button-to-LED controller: 2-FF synchroniser, per-channel debounce and
// edge detect, and a toggle/momentary LED state per channel (buttons and LEDs active-low).
module btn_led_ctrl #(
    parameter int N_CH         = 4,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_btn_n,
    input  logic [N_CH-1:0] i_mode,
    input  logic            i_clr,
    output logic [N_CH-1:0] o_led_n,
    output logic [N_CH-1:0] o_btn_state,
    output logic [N_CH-1:0] o_press_pulse,
    output logic [N_CH-1:0] o_release_pulse
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [N_CH-1:0] r_sync1_p0;
    logic [N_CH-1:0] r_sync2_p1;
    logic [N_CH-1:0] w_pressed_p1;
    logic [N_CH-1:0] w_stable_p2;
    logic [N_CH-1:0] r_stable_d_p3;
    logic [N_CH-1:0] w_rise_p3;
    logic [N_CH-1:0] w_fall_p3;
    logic [N_CH-1:0] r_press_p3;
    logic [N_CH-1:0] r_release_p3;
    logic [N_CH-1:0] r_led_p3;

    // Synchroniser: resets to the released (high) pin level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1_p0 <= '1;
            r_sync2_p1 <= '1;
        end else begin
            r_sync1_p0 <= i_btn_n;
            r_sync2_p1 <= r_sync1_p0;
        end
    end

    assign w_pressed_p1 = ~r_sync2_p1;

    // Debounce: each channel needs DEBOUNCE_CYC consecutive differing samples
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic             r_stable;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else if (w_pressed_p1[k] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt    <= '0;
                r_stable <= w_pressed_p1[k];
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_stable_p2[k] = r_stable;
    end

    assign w_rise_p3 = w_stable_p2 & ~r_stable_d_p3;
    assign w_fall_p3 = ~w_stable_p2 & r_stable_d_p3;

    // Edge detect and LED state; momentary channels copy the debounced level one cycle
    // late so the LED changes on the same edge as the matching pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable_d_p3 <= '0;
            r_press_p3    <= '0;
            r_release_p3  <= '0;
            r_led_p3      <= '0;
        end else begin
            r_stable_d_p3 <= w_stable_p2;
            r_press_p3    <= w_rise_p3;
            r_release_p3  <= w_fall_p3;
            if (i_clr) begin
                r_led_p3 <= '0;
            end else begin
                r_led_p3 <= (i_mode & w_stable_p2) | (~i_mode & (r_led_p3 ^ w_rise_p3));
            end
        end
    end

    assign o_led_n         = ~r_led_p3;
    assign o_btn_state     = w_stable_p2;
    assign o_press_pulse   = r_press_p3;
    assign o_release_pulse = r_release_p3;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Scoreboard bench for btn_led_ctrl (N_CH=4, DEBOUNCE_CYC=4): stimulus queues expected
// pulses and levels by cycle; a negedge monitor pops and compares them.
module tb_btn_led_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_n;
    logic [3:0] mode;
    logic       clr;
    logic [3:0] led_n;
    logic [3:0] btn_state;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;

    btn_led_ctrl #(
        .N_CH         (4),
        .DEBOUNCE_CYC (4)
    ) u_dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_btn_n         (btn_n),
        .i_mode          (mode),
        .i_clr           (clr),
        .o_led_n         (led_n),
        .o_btn_state     (btn_state),
        .o_press_pulse   (press_pulse),
        .o_release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  press;
        logic [3:0]  rel;
    } pulse_t;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  led_n;
        logic [3:0]  st;
        string       name;
    } lvl_t;

    pulse_t pq[$];
    lvl_t   lq[$];
    int     checks = 0;
    int     errors = 0;

    task automatic exp_pulse(input int unsigned at, input logic [3:0] pr, input logic [3:0] rl);
        pulse_t p;
        p.cyc   = at;
        p.press = pr;
        p.rel   = rl;
        pq.push_back(p);
    endtask

    task automatic exp_lvl(input int unsigned at, input logic [3:0] led, input logic [3:0] st,
                           input string nm);
        lvl_t l;
        l.cyc   = at;
        l.led_n = led;
        l.st    = st;
        l.name  = nm;
        lq.push_back(l);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pulses are popped whenever the DUT presents one; levels when their cycle comes
    always @(negedge clk) begin
        pulse_t p;
        while (pq.size() > 0 && pq[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL pulse_missing: no pulse observed, expected press=%h release=%h at cycle %0d",
                     pq[0].press, pq[0].rel, pq[0].cyc);
            void'(pq.pop_front());
        end
        if (press_pulse != 4'h0 || release_pulse != 4'h0) begin
            checks++;
            if (pq.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: press=%h release=%h at cycle %0d, expected none",
                         press_pulse, release_pulse, cyc);
            end else begin
                p = pq.pop_front();
                if (p.cyc != cyc || p.press != press_pulse || p.rel != release_pulse) begin
                    errors++;
                    $display("FAIL pulse: press=%h release=%h at cycle %0d, expected press=%h release=%h at cycle %0d",
                             press_pulse, release_pulse, cyc, p.press, p.rel, p.cyc);
                end
            end
        end
        for (int i = lq.size() - 1; i >= 0; i--) begin
            if (lq[i].cyc == cyc) begin
                checks++;
                if (led_n !== lq[i].led_n || btn_state !== lq[i].st) begin
                    errors++;
                    $display("FAIL %s: led_n=%h btn_state=%h, expected led_n=%h btn_state=%h (cycle %0d)",
                             lq[i].name, led_n, btn_state, lq[i].led_n, lq[i].st, cyc);
                end
                lq.delete(i);
            end
        end
    end

    initial begin
        int unsigned c;
        rst_n = 1'b0;
        btn_n = 4'h0;
        mode  = 4'h0;
        clr   = 1'b0;

        // Reset held with all buttons pressed, then release: all four accepted together
        step(2);
        exp_lvl(cyc + 1, 4'hF, 4'h0, "rst_hold");
        step(2);
        c = cyc;
        rst_n = 1'b1;
        exp_lvl(c + 5, 4'hF, 4'h0, "t1_pre");
        exp_lvl(c + 6, 4'hF, 4'hF, "t1_accept");
        exp_pulse(c + 7, 4'hF, 4'h0);
        exp_lvl(c + 7, 4'h0, 4'hF, "t1_lit");
        step(10);
        c = cyc;
        btn_n = 4'hF;
        exp_pulse(c + 7, 4'h0, 4'hF);
        exp_lvl(c + 7, 4'h0, 4'h0, "t1_release_hold");
        step(10);
        c = cyc;
        clr = 1'b1;
        exp_lvl(c + 1, 4'hF, 4'h0, "t1_clr");
        step(1);
        clr = 1'b0;
        step(3);

        // Toggle on ch0: press lights, release holds, second press extinguishes
        c = cyc;
        btn_n = 4'hE;
        exp_lvl(c + 5, 4'hF, 4'h0, "t2_pre");
        exp_lvl(c + 6, 4'hF, 4'h1, "t2_accept");
        exp_pulse(c + 7, 4'h1, 4'h0);
        exp_lvl(c + 7, 4'hE, 4'h1, "t2_lit");
        step(10);
        c = cyc;
        btn_n = 4'hF;
        exp_pulse(c + 7, 4'h0, 4'h1);
        exp_lvl(c + 7, 4'hE, 4'h0, "t2_release_hold");
        step(10);
        c = cyc;
        btn_n = 4'hE;
        exp_pulse(c + 7, 4'h1, 4'h0);
        exp_lvl(c + 7, 4'hF, 4'h1, "t2_toggle_off");
        step(10);
        c = cyc;
        btn_n = 4'hF;
        exp_pulse(c + 7, 4'h0, 4'h1);
        exp_lvl(c + 7, 4'hF, 4'h0, "t2_release2");
        step(10);

        // Glitch of 3 cycles on ch1 is ignored
        c = cyc;
        btn_n = 4'hD;
        step(3);
        btn_n = 4'hF;
        exp_lvl(c + 8, 4'hF, 4'h0, "t3_glitch");
        step(10);

        // Bounce 0,1,0,0,0,0: counted from the last low run
        c = cyc;
        btn_n = 4'hD;
        step(1);
        btn_n = 4'hF;
        step(1);
        btn_n = 4'hD;
        exp_lvl(c + 7, 4'hF, 4'h0, "t3_bounce_pre");
        exp_lvl(c + 8, 4'hF, 4'h2, "t3_bounce_accept");
        exp_pulse(c + 9, 4'h2, 4'h0);
        exp_lvl(c + 9, 4'hD, 4'h2, "t3_bounce_lit");
        step(10);
        c = cyc;
        btn_n = 4'hF;
        exp_pulse(c + 7, 4'h0, 4'h2);
        exp_lvl(c + 7, 4'hD, 4'h0, "t3_release_hold");
        step(10);
        c = cyc;
        clr = 1'b1;
        exp_lvl(c + 1, 4'hF, 4'h0, "t3_clr");
        step(1);
        clr = 1'b0;
        step(3);

        // Momentary ch2: LED follows the debounced button
        c = cyc;
        mode  = 4'h4;
        btn_n = 4'hB;
        exp_lvl(c + 6, 4'hF, 4'h4, "t4_accept");
        exp_pulse(c + 7, 4'h4, 4'h0);
        exp_lvl(c + 7, 4'hB, 4'h4, "t4_lit");
        step(10);
        c = cyc;
        btn_n = 4'hF;
        exp_lvl(c + 2, 4'hB, 4'h4, "t4_held");
        exp_lvl(c + 6, 4'hB, 4'h0, "t4_release_accept");
        exp_pulse(c + 7, 4'h0, 4'h4);
        exp_lvl(c + 7, 4'hF, 4'h0, "t4_off");
        step(10);

        // Momentary -> toggle while lit: LED holds, release does not change it
        c = cyc;
        btn_n = 4'hB;
        exp_pulse(c + 7, 4'h4, 4'h0);
        step(8);
        c = cyc;
        mode = 4'h0;
        exp_lvl(c + 2, 4'hB, 4'h4, "t4_m2t_hold");
        step(4);
        c = cyc;
        btn_n = 4'hF;
        exp_pulse(c + 7, 4'h0, 4'h4);
        exp_lvl(c + 8, 4'hB, 4'h0, "t4_m2t_release");
        step(10);
        c = cyc;
        clr = 1'b1;
        exp_lvl(c + 1, 4'hF, 4'h0, "t4_clr");
        step(1);
        clr = 1'b0;
        step(3);

        // All four pressed together; clear in the pulse cycle wins over toggling
        c = cyc;
        btn_n = 4'h0;
        exp_lvl(c + 6, 4'hF, 4'hF, "t5_accept");
        step(6);
        clr = 1'b1;
        exp_pulse(c + 7, 4'hF, 4'h0);
        exp_lvl(c + 7, 4'hF, 4'hF, "t5_clr_pulse");
        exp_lvl(c + 8, 4'hF, 4'hF, "t5_clr_next");
        step(2);
        clr = 1'b0;
        step(4);
        c = cyc;
        btn_n = 4'hF;
        exp_pulse(c + 7, 4'h0, 4'hF);
        exp_lvl(c + 7, 4'hF, 4'h0, "t5_release");
        step(10);

        // Reset mid-debounce on ch3 while ch0 is lit and held
        c = cyc;
        btn_n = 4'hE;
        exp_pulse(c + 7, 4'h1, 4'h0);
        exp_lvl(c + 7, 4'hE, 4'h1, "t6_ch0_lit");
        step(10);
        btn_n = 4'h6;
        step(2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_lvl(cyc, 4'hF, 4'h0, "t6_async_reset");
        step(2);
        c = cyc;
        rst_n = 1'b1;
        exp_lvl(c + 5, 4'hF, 4'h0, "t6_full_count");
        exp_lvl(c + 6, 4'hF, 4'h9, "t6_accept");
        exp_pulse(c + 7, 4'h9, 4'h0);
        exp_lvl(c + 7, 4'h6, 4'h9, "t6_lit");
        step(10);
        c = cyc;
        btn_n = 4'hF;
        exp_pulse(c + 7, 4'h0, 4'h9);
        exp_lvl(c + 7, 4'h6, 4'h0, "t6_release");
        step(12);

        while (pq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL pulse_leftover: never observed, expected press=%h release=%h at cycle %0d",
                     pq[0].press, pq[0].rel, pq[0].cyc);
            void'(pq.pop_front());
        end
        while (lq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s_leftover: not sampled, expected led_n=%h btn_state=%h at cycle %0d",
                     lq[0].name, lq[0].led_n, lq[0].st, lq[0].cyc);
            void'(lq.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
